infix_tokenizer_sy: RTL and testbench
=====================================

# infix_tokenizer_sy

Infix-to-postfix converter (shunting-yard) sitting directly upstream of the RPN evaluator. Accepts an infix token stream, one token per handshake, and emits the equivalent postfix stream as number/sign strobes, one token per cycle. Holds pending operators and parentheses on an internal operator stack. Signals end of expression, and flags malformed input with a sticky error.

## Interface
- `DEPTH`, default 16: operator stack entries (parentheses included); power of two.
- `DW`, default 8: token/number width.

- `CLK`  in  1  clock, rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `IN_DATA`  in  DW  token value: number, or ASCII `+ - * / ( )` when `IN_IS_OP`=1.
- `IN_IS_OP`  in  1  1 = operator/paren token, 0 = number.
- `IN_STB`  in  1  token valid; accepted when `IN_STB & IN_RDY`.
- `IN_END`  in  1  end of expression; accepted when `IN_END & IN_RDY`.
- `IN_RDY`  out  1  block can accept a token or end this cycle.
- `OUTPUT_NUMBER`  out  DW  postfix number, valid with `NUMBER_STB`.
- `NUMBER_STB`  out  1  one-cycle number strobe.
- `OUTPUT_SIGN`  out  8  postfix operator (ASCII), valid with `SIGN_STB`.
- `SIGN_STB`  out  1  one-cycle operator strobe.
- `DONE`  out  1  one-cycle pulse after the last postfix token of an expression.
- `BUSY`  out  1  equals `~IN_RDY`.
- `ERR`  out  1  sticky malformed-input flag.

## Operation
- States: ACCEPT, POP_PREC, POP_PAREN, FLUSH, ERROR.
- Precedence: `* /` = 2, `+ -` = 1, `(` = 0. All binary operators are left-associative.
- ACCEPT (`IN_RDY`=1), on an accepted token:
  - Number: `OUTPUT_NUMBER`<=`IN_DATA`, `NUMBER_STB`<=1.
  - `(`: push.
  - Operator op, when stack empty or top prec < prec(op): push op, stay in ACCEPT.
  - Otherwise: latch op and go to POP_PREC.
  - `)`: go to POP_PAREN.
  - Any other ASCII with `IN_IS_OP`=1: go to ERROR.
- POP_PREC: each cycle pop top, drive `OUTPUT_SIGN`=top, `SIGN_STB`=1. When the remaining top has prec < latched op, or the stack is empty, push op and return to ACCEPT.
- POP_PAREN: each cycle pop.
  - Operator: emit it.
  - `(`: discard without emission, return to ACCEPT.
  - Stack empty without finding `(`: ERROR.
- FLUSH (entered on accepted `IN_END`): pop and emit one operator per cycle.
  - Popping `(`: ERROR.
  - Stack empty: `DONE`<=1 for one cycle, return to ACCEPT.
- `IN_STB` and `IN_END` accepted in the same cycle: the token is processed first, then FLUSH (pending-end latch).
- Push with the stack full (`DEPTH` entries): ERROR, no push.
- ERROR: `ERR`=1, `IN_RDY`=0, no strobes. Left only by `RST`.
- `NUMBER_STB` and `SIGN_STB` are never high in the same cycle, except under `INFIX_SY_END_MARK_EN`.
- The block does not check operand/operator alternation. Only stack faults and bad characters raise `ERR`.

## Timing
- Reset values:
  - `IN_RDY`=1.
  - Stack pointer 0, state ACCEPT.
  - `NUMBER_STB`, `SIGN_STB`, `DONE`, `ERR`=0.
  - `OUTPUT_NUMBER`, `OUTPUT_SIGN`=0.
- Reset mid-operation discards the stack and any pending end immediately.
- All outputs are registered. A number is emitted 1 cycle after acceptance.
- `IN_RDY` falls in the cycle after accepting a token that needs pops. It stays low for exactly k cycles (k = operators popped, plus 1 for a discarded `(`). It rises in the cycle after the final pop.
- A push-only operator, `(`, or number keeps `IN_RDY`=1: back-to-back acceptance at 1 token/cycle.
- FLUSH of k operators: `SIGN_STB` on cycles 1..k after `IN_END`, `DONE` on cycle k+1. With an empty stack, `DONE` comes 1 cycle after `IN_END`.
- Output throughput: at most one postfix token per cycle. There is no downstream back-pressure; the consumer must accept every strobe.

## Configuration
- `INFIX_SY_END_MARK_EN` defined:
  - The last operator popped in FLUSH is emitted with both `SIGN_STB`=1 and `NUMBER_STB`=1 (combined-strobe end marker), with `OUTPUT_NUMBER`=0.
  - `DONE` still pulses on the following cycle.
  - If FLUSH pops zero operators, no combined strobe occurs.
- Not defined: strobes are mutually exclusive; end of expression is signalled by `DONE` only.

## Test plan
- `3 + 4 * 2`, then `IN_END`, tokens back to back -> output order `3 4 2 * +`; `IN_RDY` never drops; `DONE` 3 cycles after `IN_END`.
- `( 1 + 2 ) * 3`, then `IN_END` -> `1 2 + 3 *`; `IN_RDY` low 2 cycles after `)`; `(` never emitted.
- `8 - 3 - 2`, then `IN_END` -> `8 3 - 2 -` (left associativity; first `-` popped by the second).
- Error cases:
  - `1 + 2 )` -> `ERR`=1 after POP_PAREN empties; `IN_RDY`=0 until `RST`.
  - 17 consecutive `(` with `DEPTH`=16 -> `ERR` on the 17th.
  - `( 5` + `IN_END` -> `ERR` in FLUSH.
- `RST` asserted mid-FLUSH of `1+2*3` -> outputs return to reset values the same cycle; a following `7` + `IN_END` -> `NUMBER_STB` with 7, `DONE`, no `SIGN_STB`.
- With `INFIX_SY_END_MARK_EN`: `6 / 2` + `IN_END` -> `/` emitted with both strobes high, `DONE` next cycle.

Source files
------------

// File: rtl/infix_tokenizer_sy.sv
// infix_tokenizer_sy: shunting-yard infix-to-postfix converter feeding the RPN evaluator.
// Optional INFIX_SY_END_MARK_EN: the final flushed operator also raises NUMBER_STB (end marker).
`timescale 1ns/1ps
module infix_tokenizer_sy #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [DW-1:0] IN_DATA,
  input  logic          IN_IS_OP,
  input  logic          IN_STB,
  input  logic          IN_END,
  output logic          IN_RDY,
  output logic [DW-1:0] OUTPUT_NUMBER,
  output logic          NUMBER_STB,
  output logic [7:0]    OUTPUT_SIGN,
  output logic          SIGN_STB,
  output logic          DONE,
  output logic          BUSY,
  output logic          ERR
);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SPW = AW + 1;
`ifdef INFIX_SY_END_MARK_EN
  localparam bit END_MARK = 1'b1;
`else
  localparam bit END_MARK = 1'b0;
`endif
  localparam logic [7:0] LP  = 8'h28;
  localparam logic [7:0] RP  = 8'h29;
  localparam logic [7:0] MUL = 8'h2A;
  localparam logic [7:0] ADD = 8'h2B;
  localparam logic [7:0] SUB = 8'h2D;
  localparam logic [7:0] DIV = 8'h2F;

  typedef enum logic [2:0] {ACCEPT, POP_PREC, POP_PAREN, FLUSH, ERROR} state_t;
  state_t state, nxt, ret_state;

  logic [7:0]     stack_mem [DEPTH];
  logic [SPW-1:0] sp;
  logic [AW-1:0]  wr_idx;
  logic [7:0]     op_q, top, below, tok, push_val, sign_q;
  logic           pend_end;
  logic           empty, full, one_left;
  logic           is_lp, is_rp, is_bin, bad_tok, prec_pops, tok_push, tok_full, prec_stop;
  logic           push, pop, emit_num, emit_sign, mark, done_n;
  logic           rdy_q, num_stb_q, sign_stb_q, done_q, err_q;
  logic [DW-1:0]  number_q;

  function automatic logic [1:0] prec(input logic [7:0] c);
    case (c)
      MUL, DIV: prec = 2'd2;
      ADD, SUB: prec = 2'd1;
      default:  prec = 2'd0;
    endcase
  endfunction

  assign tok       = IN_DATA[7:0];
  assign is_lp     = (IN_DATA == DW'(LP));
  assign is_rp     = (IN_DATA == DW'(RP));
  assign is_bin    = (IN_DATA == DW'(MUL)) | (IN_DATA == DW'(DIV)) |
                     (IN_DATA == DW'(ADD)) | (IN_DATA == DW'(SUB));
  assign bad_tok   = IN_IS_OP & ~(is_lp | is_rp | is_bin);

  assign empty     = (sp == '0);
  assign full      = (sp == SPW'(DEPTH));
  assign one_left  = (sp == SPW'(1));
  assign top       = stack_mem[AW'(sp - SPW'(1))];
  assign below     = stack_mem[AW'(sp - SPW'(2))];

  // an incoming operator pops when the top binds at least as tightly (left associativity)
  assign prec_pops = ~empty & (prec(top) >= prec(tok));
  assign tok_push  = IN_IS_OP & (is_lp | (is_bin & ~prec_pops));
  assign tok_full  = tok_push & full;
  assign prec_stop = (sp <= SPW'(1)) | (prec(below) < prec(op_q));
  assign ret_state = pend_end ? FLUSH : ACCEPT;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ACCEPT;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ACCEPT: begin
        if (IN_STB) begin
          if (bad_tok || tok_full)              nxt = ERROR;
          else if (IN_IS_OP && is_rp)           nxt = POP_PAREN;
          else if (IN_IS_OP && is_bin && prec_pops) nxt = POP_PREC;
          else if (IN_END)                      nxt = FLUSH;
        end else if (IN_END && !empty) begin
          nxt = (top == LP) ? ERROR : FLUSH;
        end
      end
      POP_PREC:  if (prec_stop) nxt = ret_state;
      POP_PAREN: begin
        if (empty)            nxt = ERROR;
        else if (top == LP)   nxt = ret_state;
      end
      FLUSH: begin
        if (empty)            nxt = ACCEPT;
        else if (top == LP)   nxt = ERROR;
      end
      ERROR:   nxt = ERROR;
      default: nxt = ACCEPT;
    endcase
  end

  // IN_END in ACCEPT performs the first flush step at once so the first sign lands 1 cycle later
  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    push_val  = tok;
    emit_num  = 1'b0;
    emit_sign = 1'b0;
    mark      = 1'b0;
    done_n    = 1'b0;
    case (state)
      ACCEPT: begin
        if (IN_STB) begin
          if (!bad_tok && !tok_full) begin
            emit_num = ~IN_IS_OP;
            push     = tok_push;
          end
        end else if (IN_END) begin
          if (empty) done_n = 1'b1;
          else if (top != LP) begin
            pop       = 1'b1;
            emit_sign = 1'b1;
            mark      = END_MARK & one_left;
          end
        end
      end
      POP_PREC: begin
        pop       = 1'b1;
        emit_sign = 1'b1;
        push      = prec_stop;
        push_val  = op_q;
      end
      POP_PAREN: begin
        if (!empty) begin
          pop       = 1'b1;
          emit_sign = (top != LP);
        end
      end
      FLUSH: begin
        if (empty) done_n = 1'b1;
        else if (top != LP) begin
          pop       = 1'b1;
          emit_sign = 1'b1;
          mark      = END_MARK & one_left;
        end
      end
      default: ;
    endcase
  end

  // pop+push replaces the top entry in place
  assign wr_idx = pop ? AW'(sp - SPW'(1)) : AW'(sp);

  always_ff @(posedge CLK) begin
    if (push) stack_mem[wr_idx] <= push_val;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sp         <= '0;
      op_q       <= '0;
      pend_end   <= 1'b0;
      rdy_q      <= 1'b1;
      num_stb_q  <= 1'b0;
      sign_stb_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      number_q   <= '0;
      sign_q     <= '0;
    end else begin
      if (push && !pop)      sp <= sp + SPW'(1);
      else if (pop && !push) sp <= sp - SPW'(1);
      if (state == ACCEPT && IN_STB) begin
        op_q     <= tok;
        pend_end <= IN_END;
      end
      rdy_q      <= (nxt == ACCEPT);
      err_q      <= (nxt == ERROR);
      done_q     <= done_n;
      num_stb_q  <= emit_num | mark;
      sign_stb_q <= emit_sign;
      if (emit_num)  number_q <= IN_DATA;
      else if (mark) number_q <= '0;
      if (emit_sign) sign_q <= top;
    end
  end

  assign IN_RDY        = rdy_q;
  assign BUSY          = ~rdy_q;
  assign ERR           = err_q;
  assign DONE          = done_q;
  assign NUMBER_STB    = num_stb_q;
  assign SIGN_STB      = sign_stb_q;
  assign OUTPUT_NUMBER = number_q;
  assign OUTPUT_SIGN   = sign_q;
endmodule

// File: tb/tb_infix_tokenizer_sy.sv
// Bench for infix_tokenizer_sy: directed timing/error cases plus random expressions
// compared with a queue-based shunting-yard reference model.
`timescale 1ns/1ps
module tb_infix_tokenizer_sy;
  localparam int DEPTH = 16;
  localparam int DW    = 8;
`ifdef INFIX_SY_END_MARK_EN
  localparam bit END_MARK = 1'b1;
`else
  localparam bit END_MARK = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] IN_DATA;
  logic          IN_IS_OP, IN_STB, IN_END;
  logic          IN_RDY, NUMBER_STB, SIGN_STB, DONE, BUSY, ERR;
  logic [DW-1:0] OUTPUT_NUMBER;
  logic [7:0]    OUTPUT_SIGN;

  infix_tokenizer_sy #(.DEPTH(DEPTH), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_IS_OP(IN_IS_OP), .IN_STB(IN_STB),
    .IN_END(IN_END), .IN_RDY(IN_RDY), .OUTPUT_NUMBER(OUTPUT_NUMBER), .NUMBER_STB(NUMBER_STB),
    .OUTPUT_SIGN(OUTPUT_SIGN), .SIGN_STB(SIGN_STB), .DONE(DONE), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // observed postfix stream: {num_stb, sign_stb, value}
  logic [9:0] outq[$];
  logic [8:0] tokq[$];
  logic [9:0] expq[$];
  bit exp_err, exp_done;
  int done_cnt = 0, done_cyc = 0, end_cyc = 0, last_waits = 0;
  int both_total = 0, mark_bad = 0;

  always @(negedge CLK) begin
    if (NUMBER_STB && SIGN_STB) begin
      both_total++;
      if (OUTPUT_NUMBER != '0) mark_bad++;
      outq.push_back({2'b11, OUTPUT_SIGN});
    end else if (NUMBER_STB) outq.push_back({2'b10, OUTPUT_NUMBER[7:0]});
    else if (SIGN_STB)       outq.push_back({2'b01, OUTPUT_SIGN});
    if (DONE) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic send(input bit stb, input bit is_op, input logic [7:0] val, input bit endf);
    int w = 0;
    @(negedge CLK);
    while (!IN_RDY && w < 64) begin
      w++;
      @(negedge CLK);
    end
    last_waits = w;
    if (!IN_RDY) begin
      chk("send_rdy_timeout", {31'd0, IN_RDY}, 32'd1);
      return;
    end
    IN_DATA = val; IN_IS_OP = is_op; IN_STB = stb; IN_END = endf;
    if (stb) tokq.push_back({is_op, val});
    @(posedge CLK);
    #1;
    IN_STB = 1'b0; IN_END = 1'b0;
    if (endf) end_cyc = cyc;
  endtask

  task automatic t_num(input logic [7:0] v); send(1'b1, 1'b0, v, 1'b0); endtask
  task automatic t_op(input logic [7:0] c);  send(1'b1, 1'b1, c, 1'b0); endtask
  task automatic t_end();                    send(1'b0, 1'b0, 8'h00, 1'b1); endtask

  function automatic int prec_of(input logic [7:0] c);
    if (c == 8'h2A || c == 8'h2F) return 2;
    if (c == 8'h2B || c == 8'h2D) return 1;
    return 0;
  endfunction

  function automatic bit is_binop(input logic [7:0] c);
    return (c == 8'h2A || c == 8'h2F || c == 8'h2B || c == 8'h2D);
  endfunction

  // textbook shunting-yard over the token list, stopping at the first fault
  task automatic model(input bit with_end);
    logic [7:0] stk[$];
    logic [7:0] c;
    logic [9:0] e;
    expq.delete();
    exp_err = 1'b0;
    exp_done = 1'b0;
    foreach (tokq[i]) begin
      if (exp_err) break;
      c = tokq[i][7:0];
      if (!tokq[i][8]) expq.push_back({2'b10, c});
      else if (c == 8'h28) begin
        if (stk.size() == DEPTH) exp_err = 1'b1; else stk.push_back(c);
      end else if (is_binop(c)) begin
        while (stk.size() > 0 && prec_of(stk[$]) >= prec_of(c)) expq.push_back({2'b01, stk.pop_back()});
        if (stk.size() == DEPTH) exp_err = 1'b1; else stk.push_back(c);
      end else if (c == 8'h29) begin
        while (stk.size() > 0 && stk[$] != 8'h28) expq.push_back({2'b01, stk.pop_back()});
        if (stk.size() == 0) exp_err = 1'b1; else void'(stk.pop_back());
      end else exp_err = 1'b1;
    end
    if (with_end && !exp_err) begin
      while (stk.size() > 0 && !exp_err) begin
        if (stk[$] == 8'h28) exp_err = 1'b1;
        else begin
          e = {2'b01, stk.pop_back()};
          if (stk.size() == 0 && END_MARK) e[9] = 1'b1;
          expq.push_back(e);
        end
      end
      if (!exp_err) exp_done = 1'b1;
    end
  endtask

  task automatic check_stream(input string tag);
    int n;
    step();
    chk({tag, "_len"}, outq.size(), expq.size());
    n = (outq.size() < expq.size()) ? outq.size() : expq.size();
    for (int i = 0; i < n; i++) chk({tag, "_tok"}, {22'd0, outq[i]}, {22'd0, expq[i]});
    outq.delete();
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && !ERR && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic wait_err();
    int n = 0;
    while (!ERR && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    step();
    outq.delete();
    tokq.delete();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int stalls, low, d0, depth, nnum, len, guard;
    bit want_operand;
    logic [7:0] ops[4];
    ops[0] = 8'h2B; ops[1] = 8'h2D; ops[2] = 8'h2A; ops[3] = 8'h2F;
    RST = 1'b1; IN_DATA = '0; IN_IS_OP = 1'b0; IN_STB = 1'b0; IN_END = 1'b0;
    step(); step();
    chk("rst_rdy", IN_RDY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_nstb", NUMBER_STB, 0);
    chk("rst_sstb", SIGN_STB, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_num", OUTPUT_NUMBER, 0);
    chk("rst_sign", OUTPUT_SIGN, 0);
    RST = 1'b0;
    outq.delete();

    // 3 + 4 * 2 back to back
    tokq.delete(); stalls = 0; d0 = done_cnt;
    t_num(3);     stalls += last_waits;
    t_op(8'h2B);  stalls += last_waits;
    t_num(4);     stalls += last_waits;
    t_op(8'h2A);  stalls += last_waits;
    t_num(2);     stalls += last_waits;
    t_end();      stalls += last_waits;
    wait_done(d0);
    chk("a_stall", stalls, 0);
    chk("a_done_cnt", done_cnt - d0, 1);
    chk("a_done_lat", done_cyc - end_cyc, 2);
    model(1'b1);
    check_stream("a");

    // ( 1 + 2 ) * 3
    tokq.delete(); d0 = done_cnt;
    t_op(8'h28); t_num(1); t_op(8'h2B); t_num(2); t_op(8'h29);
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (IN_RDY) break;
      low++;
    end
    chk("b_rdy_low", low, 2);
    t_op(8'h2A); t_num(3); t_end();
    wait_done(d0);
    chk("b_done_cnt", done_cnt - d0, 1);
    model(1'b1);
    check_stream("b");

    // 8 - 3 - 2
    tokq.delete(); d0 = done_cnt;
    t_num(8); t_op(8'h2D); t_num(3); t_op(8'h2D);
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (IN_RDY) break;
      low++;
    end
    chk("c_rdy_low", low, 1);
    t_num(2); t_end();
    wait_done(d0);
    chk("c_done_cnt", done_cnt - d0, 1);
    model(1'b1);
    check_stream("c");

    // 6 / 2 : end marker build sees a combined strobe, DONE one cycle after
    tokq.delete(); d0 = done_cnt;
    t_num(6); t_op(8'h2F); t_num(2); t_end();
    wait_done(d0);
    chk("h_done_lat", done_cyc - end_cyc, 1);
    model(1'b1);
    check_stream("h");

    // unmatched ')'
    tokq.delete();
    t_num(1); t_op(8'h2B); t_num(2); t_op(8'h29);
    wait_err();
    chk("d_err", ERR, 1);
    model(1'b0);
    chk("d_model_err", ERR, exp_err);
    check_stream("d");
    repeat (5) step();
    chk("d_rdy_stuck", IN_RDY, 0);
    chk("d_busy", BUSY, 1);
    chk("d_err_sticky", ERR, 1);
    chk("d_no_strobes", outq.size(), 0);
    do_reset();
    chk("d_rst_err", ERR, 0);

    // stack overflow on the 17th '('
    tokq.delete(); stalls = 0;
    for (int i = 0; i < DEPTH; i++) begin
      t_op(8'h28);
      stalls += last_waits;
    end
    chk("e_stall", stalls, 0);
    chk("e_no_err16", ERR, 0);
    t_op(8'h28);
    chk("e_err17", ERR, 1);
    chk("e_rdy17", IN_RDY, 0);
    do_reset();

    // ( 5 then end: stray '(' found by flush
    tokq.delete(); d0 = done_cnt;
    t_op(8'h28); t_num(5); t_end();
    wait_err();
    chk("f_err", ERR, 1);
    chk("f_no_done", done_cnt - d0, 0);
    model(1'b1);
    check_stream("f");
    do_reset();

    // reset in the middle of flushing 1 + 2 * 3
    tokq.delete();
    t_num(1); t_op(8'h2B); t_num(2); t_op(8'h2A); t_num(3); t_end();
    chk("g_mid_flush", SIGN_STB, 1);
    chk("g_mid_sign", OUTPUT_SIGN, 8'h2A);
    RST = 1'b1;
    #1;
    chk("g_rst_sstb", SIGN_STB, 0);
    chk("g_rst_nstb", NUMBER_STB, 0);
    chk("g_rst_sign", OUTPUT_SIGN, 0);
    chk("g_rst_num", OUTPUT_NUMBER, 0);
    chk("g_rst_rdy", IN_RDY, 1);
    chk("g_rst_done", DONE, 0);
    step();
    outq.delete(); tokq.delete();
    RST = 1'b0;
    d0 = done_cnt;
    t_num(7); t_end();
    wait_done(d0);
    chk("g_done_cnt", done_cnt - d0, 1);
    chk("g_err", ERR, 0);
    model(1'b1);
    check_stream("g");

    // random well-formed expressions, random gaps, sometimes token+end together
    for (int e = 0; e < 40; e++) begin
      logic [8:0] gen[$];
      bit comb_end;
      gen.delete(); tokq.delete();
      depth = 0; nnum = 0; want_operand = 1'b1; guard = 0;
      len = $urandom_range(1, 10);
      while (guard < 100) begin
        guard++;
        if (want_operand) begin
          if (depth < 4 && $urandom_range(0, 3) == 0) begin
            gen.push_back({1'b1, 8'h28}); depth++;
          end else begin
            gen.push_back({1'b0, 8'($urandom_range(0, 255))}); nnum++; want_operand = 1'b0;
          end
        end else if (depth > 0 && $urandom_range(0, 2) == 0) begin
          gen.push_back({1'b1, 8'h29}); depth--;
        end else if (nnum >= len) break;
        else begin
          gen.push_back({1'b1, ops[$urandom_range(0, 3)]}); want_operand = 1'b1;
        end
      end
      while (depth > 0) begin
        gen.push_back({1'b1, 8'h29}); depth--;
      end
      comb_end = ($urandom_range(0, 1) == 1);
      d0 = done_cnt;
      foreach (gen[i]) begin
        repeat ($urandom_range(0, 2)) @(negedge CLK);
        send(1'b1, gen[i][8], gen[i][7:0], comb_end && (i == gen.size() - 1));
      end
      if (!comb_end) t_end();
      wait_done(d0);
      model(1'b1);
      chk("r_done_cnt", done_cnt - d0, {31'd0, exp_done});
      chk("r_err", ERR, {31'd0, exp_err});
      check_stream("r");
      if (ERR) do_reset();
    end

`ifdef INFIX_SY_END_MARK_EN
    chk("mark_number_zero", mark_bad, 0);
`else
    chk("strobes_exclusive", both_total, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
